// File: rtl/ram_3port_sched.sv
// ram_3port_sched: one writer and two readers sharing a 3-port RAM, zero-fill on reset.
// Define RAM_3PORT_SCHED_FWD_EN to forward write data to reader 2 on same-address collisions.
module ram_3port_sched #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,

  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,

  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata,

  input  logic                  rd2_valid,
  output logic                  rd2_ready,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic                  rd2_rvalid,
  output logic [DATA_WIDTH-1:0] rd2_rdata,

  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic [ADDR_WIDTH-1:0] ram_read_addr1,
  output logic [ADDR_WIDTH-1:0] ram_read_addr2,
  input  logic [DATA_WIDTH-1:0] ram_read_data1,
  input  logic [DATA_WIDTH-1:0] ram_read_data2
);

  localparam int CW = $clog2(MAX_WR_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(MAX_WR_BURST);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [CW-1:0]         burst_cnt;

  logic run;
  logic wr_fire;
  logic rd1_fire;
  logic rd2_fire;
  logic collide;

  // Ready is held low while rst is asserted so nothing fires into a restart.
  always_comb begin
    run       = (state == ST_RUN) & ~rst;
    wr_ready  = run & (~rd1_valid | (burst_cnt < BMAX));
    rd1_ready = run & (~wr_valid | (burst_cnt == BMAX));
    wr_fire   = wr_valid & wr_ready;
    rd1_fire  = rd1_valid & rd1_ready;
    collide   = wr_fire & (wr_addr == rd2_addr);
`ifdef RAM_3PORT_SCHED_FWD_EN
    rd2_ready = run;
`else
    rd2_ready = run & ~collide;
`endif
    rd2_fire  = rd2_valid & rd2_ready;
  end

  always_comb begin
    ram_write_en   = 1'b1;
    ram_write_addr = sweep_cnt;
    ram_write_data = '0;
    if (run) begin
      ram_write_en   = wr_fire;
      ram_write_addr = wr_addr;
      ram_write_data = wr_data;
    end
    ram_read_addr1 = rd1_addr;
    ram_read_addr2 = rd2_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      sweep_cnt  <= '0;
      init_done  <= 1'b0;
      burst_cnt  <= '0;
      rd1_rvalid <= 1'b0;
      rd2_rvalid <= 1'b0;
      rd1_rdata  <= '0;
      rd2_rdata  <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (&sweep_cnt) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: state <= ST_INIT;
      endcase

      if (~rd1_valid | rd1_fire)
        burst_cnt <= '0;
      else if (wr_fire)
        burst_cnt <= burst_cnt + 1'b1;

      rd1_rvalid <= rd1_fire;
      if (rd1_fire)
        rd1_rdata <= ram_read_data1;

      // The RAM returns pre-write data on a same-cycle collision.
      rd2_rvalid <= rd2_fire;
      if (rd2_fire)
        rd2_rdata <= collide ? wr_data : ram_read_data2;
    end
  end

endmodule
